// File: rtl/lab2_proc_imul_pkg.sv
// rtl/lab2_proc_imul_pkg.sv - shared types and sizing for the iterative multiplier
package lab2_proc_imul_pkg;

  localparam int unsigned IMUL_NBITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } imul_state_e;

  typedef struct packed {
    logic [IMUL_NBITS-1:0] a;
    logic [IMUL_NBITS-1:0] b;
  } imul_req_t;

  // Step counter must reach nbits-1; keep at least one bit for tiny widths.
  function automatic int imul_cnt_w(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

  localparam int unsigned IMUL_CNT_W = imul_cnt_w(IMUL_NBITS);

endpackage

// File: rtl/lab2_proc_imul_iter_if.sv
// rtl/lab2_proc_imul_iter_if.sv - request/response handshake bundle for the multiplier
interface lab2_proc_imul_iter_if #(
  parameter int unsigned p_nbits = 32
);

  logic                   req_val;
  logic                   req_rdy;
  logic [2*p_nbits-1:0]   req_msg;
  logic                   resp_val;
  logic                   resp_rdy;
  logic [p_nbits-1:0]     resp_msg;

  modport master (
    output req_val,
    output req_msg,
    output resp_rdy,
    input  req_rdy,
    input  resp_val,
    input  resp_msg
  );

  modport slave (
    input  req_val,
    input  req_msg,
    input  resp_rdy,
    output req_rdy,
    output resp_val,
    output resp_msg
  );

endinterface

// File: rtl/lab2_proc_imul_iter_ctrl.sv
// rtl/lab2_proc_imul_iter_ctrl.sv - IDLE/CALC/DONE sequencer, step counter and handshakes
module lab2_proc_imul_iter_ctrl
  import lab2_proc_imul_pkg::*;
#(
  parameter int unsigned p_nbits      = IMUL_NBITS,
  parameter bit          p_early_term = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req_val,
  input  logic i_resp_rdy,
  input  logic i_b_rest_zero,
  output logic o_req_rdy,
  output logic o_resp_val,
  output logic o_load,
  output logic o_step
);

  localparam int unsigned         CW   = imul_cnt_w(p_nbits);
  localparam logic [CW-1:0]       LAST = CW'(p_nbits - 1);

  imul_state_e      r_state;
  imul_state_e      w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_req_rdy   = 1'b0;
    o_resp_val  = 1'b0;
    o_load      = 1'b0;
    o_step      = 1'b0;
    // Decided on the current step: this edge shifts out the last useful b bit.
    w_done      = (r_cnt == LAST) || (p_early_term && i_b_rest_zero);

    case (r_state)
      IDLE: begin
        o_req_rdy = !reset;
        if (i_req_val && o_req_rdy) begin
          o_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        o_step    = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_done) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_resp_val = !reset;
        if (i_resp_rdy) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/lab2_proc_imul_iter.sv
// rtl/lab2_proc_imul_iter.sv - iterative shift-add multiplier returning the low product bits
module lab2_proc_imul_iter
  import lab2_proc_imul_pkg::*;
#(
  parameter int unsigned p_nbits      = IMUL_NBITS,
  parameter bit          p_early_term = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  lab2_proc_imul_iter_if.slave  io
);

  logic [p_nbits-1:0] r_a;
  logic [p_nbits-1:0] r_b;
  logic [p_nbits-1:0] r_result;

  logic w_load;
  logic w_step;
  logic w_b_rest_zero;
  logic w_req_rdy;
  logic w_resp_val;

  assign w_b_rest_zero = ((r_b >> 1) == '0);

  lab2_proc_imul_iter_ctrl #(
    .p_nbits      (p_nbits),
    .p_early_term (p_early_term)
  ) u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .i_req_val     (io.req_val),
    .i_resp_rdy    (io.resp_rdy),
    .i_b_rest_zero (w_b_rest_zero),
    .o_req_rdy     (w_req_rdy),
    .o_resp_val    (w_resp_val),
    .o_load        (w_load),
    .o_step        (w_step)
  );

  // Low bits only: wraparound of the accumulator is the intended MUL result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_load) begin
      r_a      <= io.req_msg[2*p_nbits-1:p_nbits];
      r_b      <= io.req_msg[p_nbits-1:0];
      r_result <= '0;
    end else if (w_step) begin
      if (r_b[0]) begin
        r_result <= r_result + r_a;
      end
      r_a <= r_a << 1;
      r_b <= r_b >> 1;
    end
  end

  assign io.req_rdy  = w_req_rdy;
  assign io.resp_val = w_resp_val;
  assign io.resp_msg = r_result;

endmodule

// File: doc/lab2_proc_imul_iter.md
Name: lab2_proc_imul_iter

Overview:
Iterative shift-add integer multiplier that sits downstream of the processor base datapath. Decode issues multiply requests on the req interface (imul_req_val_D / imul_req_rdy_D). X consumes results on the resp interface (imul_resp_val_X / imul_resp_rdy_X). It produces the low p_nbits of the product (MUL semantics), with variable latency through early termination on the multiplier operand.

Parameters:
p_nbits, 32, operand and result width in bits
p_early_term, 1, 1 = leave CALC when the remaining multiplier bits are zero; 0 = always run p_nbits steps

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_val  input  1  request valid
req_rdy  output  1  request ready
req_msg  input  2*p_nbits  operands: a = [2*p_nbits-1:p_nbits], b = [p_nbits-1:0]
resp_val  output  1  response valid
resp_rdy  input  1  response ready
resp_msg  output  p_nbits  product low bits

Behaviour:
- Single clock clk; reset is synchronous and active-high. All state updates on posedge clk.
- Handshake: transfer occurs in a cycle where val && rdy. Sender holds val and msg stable until transfer. val must not depend combinationally on rdy.
- States:
  - IDLE: req_rdy=1, resp_val=0.
  - CALC: req_rdy=0, resp_val=0.
  - DONE: req_rdy=0, resp_val=1.
- IDLE -> CALC on req transfer. The same edge latches a_reg=a, b_reg=b, result=0, cnt=0.
- Each CALC edge:
  - if b_reg[0], result += a_reg (mod 2^p_nbits)
  - a_reg <<= 1
  - b_reg >>= 1 (logical shift)
  - cnt += 1
- CALC -> DONE on the edge where cnt==p_nbits-1, or where p_early_term && (b_reg>>1)==0.
- CALC always executes at least one step.
- DONE -> IDLE on resp transfer. resp_msg = result.
- No overlap: a new request can be accepted only in IDLE, earliest the cycle after the resp transfer.
- Latency: k = max(1, index of highest set bit of b + 1), or k = p_nbits when p_early_term=0.
  - Request accepted in cycle 0 gives resp_val high in cycle k+1.
- Backpressure: while in DONE with resp_rdy=0, resp_val and resp_msg hold unchanged indefinitely.
- Signed and unsigned operands give identical low bits. No sign handling is required.
- cnt width is clog2(p_nbits).
- Reset values:
  - state=IDLE, result=0, a_reg=0, b_reg=0, cnt=0.
  - req_rdy=0 while reset is asserted; 1 from the first cycle after deassertion.
  - resp_val=0, resp_msg=0.
- Reset asserted in CALC or DONE aborts the operation. The in-flight result is discarded and never presented.
- req_val high during reset is ignored; no transfer occurs.

Decomposition:
- Shared package lab2_proc_imul_pkg:
  - state enum {IDLE, CALC, DONE}
  - packed struct imul_req_t {a, b}
  - localparam for cnt width
- Natural split into control and datapath:
  - control FSM lab2_proc_imul_iter_ctrl: state register, cnt, handshake outputs, done detection
  - shift/add datapath inline in the top module

Test Plan:
- Basic: a=3, b=5, resp_rdy=1, req accepted in cycle 0 -> resp_val=1 in cycle 4 (k=3), resp_msg=15; req_rdy=1 again in cycle 5.
- Zero multiplier: a=0xDEADBEEF, b=0 -> resp_val=1 in cycle 2 (k=1), resp_msg=0x00000000.
- Full length: a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_val=1 in cycle 33, resp_msg=0x00000001. With p_early_term=0 and b=1, resp_val is also in cycle 33.
- Negative operand: a=0xFFFFFFF9 (-7), b=6 -> resp_val=1 in cycle 4, resp_msg=0xFFFFFFD6 (-42).
- Backpressure: a=4, b=4 with resp_rdy=0 for 5 cycles after resp_val rises -> resp_val=1, resp_msg=16, req_rdy=0 held throughout. Raise resp_rdy, then req_rdy=1 the next cycle and a second request a=2, b=2 returns 4.
- Reset mid-operation: assert reset for 1 cycle during CALC of a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_val never asserts for that request, req_rdy=1 the cycle after reset deasserts, and the next request a=7, b=3 returns 21.
